// File: rtl/mc_alu_control_unit_if.sv
// Control bus between the multi-cycle control unit and the memory/datapath side.
//
// Signals:
//   opcode, funct  instruction fields from the instruction register
//   mem_ready      memory completes its access this cycle
//   zero           ALU zero flag
//   state          current controller state (debug)
//   mem_read, mem_write, ir_write, pc_write, pc_write_cond, pc_src,
//   alu_src_b, alu_sel, reg_write, reg_dst, mem_to_reg, illegal, mem_err
//                  datapath/memory controls driven by the control unit
//
// Modports: master = control unit, slave = datapath/memory side.
// SEL_W must match the SEL_W of the control unit bound to this interface.
interface mc_alu_control_unit_if #(
  parameter int unsigned SEL_W = 4
) ();
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             mem_ready;
  logic             zero;
  logic [2:0]       state;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             pc_write;
  logic             pc_write_cond;
  logic [1:0]       pc_src;
  logic [1:0]       alu_src_b;
  logic [SEL_W-1:0] alu_sel;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             illegal;
  logic             mem_err;

  modport master (
    input  opcode, funct, mem_ready, zero,
    output state, mem_read, mem_write, ir_write, pc_write, pc_write_cond, pc_src,
           alu_src_b, alu_sel, reg_write, reg_dst, mem_to_reg, illegal, mem_err
  );

  modport slave (
    output opcode, funct, mem_ready, zero,
    input  state, mem_read, mem_write, ir_write, pc_write, pc_write_cond, pc_src,
           alu_src_b, alu_sel, reg_write, reg_dst, mem_to_reg, illegal, mem_err
  );
endinterface

// File: rtl/mc_alu_control_unit.sv
// Multi-cycle MIPS32 control unit: sequences each instruction through
// FETCH(0) / DECODE(1) / EXEC(2) / MEM(3) / WB(4) and drives the datapath
// enables plus an SEL_W-bit ALU select (bits above [3] are always 0).
// Supports R-type (and/or/add/sub/slt/nor/sll/srl/xor), lw, sw, addi, beq, j.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; aborts the current instruction
//   bus    mc_alu_control_unit_if.master (instruction fields, mem_ready, zero in;
//          all control outputs out)
//
// Build option: define MEM_TIMEOUT_EN to abort a memory wait (FETCH or MEM) after
// MEM_TIMEOUT cycles of mem_ready=0 with a one-cycle mem_err pulse and a refetch.
// Without it mem_err is tied 0 and the controller waits indefinitely.
module mc_alu_control_unit #(
  parameter int unsigned SEL_W       = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 4
) (
  input logic                  clk,
  input logic                  reset,
  mc_alu_control_unit_if.master bus
);

  if (SEL_W < 4) begin : g_sel_w_check
    $error("SEL_W must be at least 4");
  end
  if ((64'd1 << TO_W) <= 64'(MEM_TIMEOUT)) begin : g_to_w_check
    $error("TO_W too narrow for MEM_TIMEOUT");
  end

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNor = 4'b1100;
  localparam logic [3:0] AluSll = 4'b1000;
  localparam logic [3:0] AluSrl = 4'b1001;
  localparam logic [3:0] AluXor = 4'b1010;

  // {legal, alu op} for an R-type funct field.
  function automatic logic [4:0] funct_decode(input logic [5:0] f);
    case (f)
      6'b100100: funct_decode = {1'b1, AluAnd};
      6'b100101: funct_decode = {1'b1, AluOr};
      6'b100000: funct_decode = {1'b1, AluAdd};
      6'b100010: funct_decode = {1'b1, AluSub};
      6'b101010: funct_decode = {1'b1, AluSlt};
      6'b100111: funct_decode = {1'b1, AluNor};
      6'b000000: funct_decode = {1'b1, AluSll};
      6'b000010: funct_decode = {1'b1, AluSrl};
      6'b100110: funct_decode = {1'b1, AluXor};
      default:   funct_decode = {1'b0, AluAnd};
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [5:0]       opcode_q, funct_q;
  logic             legal;
  logic [4:0]       fdec_live, fdec_q;
  logic [3:0]       alu_sel4;
  logic [SEL_W-1:0] alu_sel_w;
  logic             timeout;
  logic             mem_read, mem_write, ir_write, pc_write, pc_write_cond;
  logic [1:0]       pc_src, alu_src_b;
  logic             reg_write, reg_dst, mem_to_reg, illegal, mem_err;

`ifdef MEM_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q;
  logic            waiting;

  assign waiting = ((state_q == StFetch) || (state_q == StMem)) && !bus.mem_ready;
  // Fires on the MEM_TIMEOUT-th consecutive wait cycle.
  assign timeout = waiting && (to_cnt_q == TO_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else if (waiting && !timeout) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end else begin
      to_cnt_q <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign fdec_live = funct_decode(bus.funct);
  assign fdec_q    = funct_decode(funct_q);

  // Legality is judged on the live fields during DECODE, while they are being latched.
  // Unknown opcode bits fall to the default arm and read as illegal.
  always_comb begin
    case (bus.opcode)
      OpRtype:                         legal = fdec_live[4];
      OpLw, OpSw, OpBeq, OpAddi, OpJ:  legal = 1'b1;
      default:                         legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'd0;
    alu_src_b     = 2'd0;
    alu_sel4      = AluAnd;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    illegal       = 1'b0;
    mem_err       = 1'b0;
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        alu_sel4  = AluAdd;
        if (timeout) begin
          mem_err = 1'b1;
        end else if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        alu_src_b = 2'd3;
        alu_sel4  = AluAdd;
        if (legal) begin
          state_d = StExec;
        end else begin
          illegal = 1'b1;
          state_d = StFetch;
        end
      end
      StExec: begin
        case (opcode_q)
          OpRtype: begin
            alu_sel4 = fdec_q[3:0];
            state_d  = StWb;
          end
          OpLw, OpSw, OpAddi: begin
            alu_src_b = 2'd2;
            alu_sel4  = AluAdd;
            state_d   = (opcode_q == OpAddi) ? StWb : StMem;
          end
          OpBeq: begin
            alu_sel4      = AluSub;
            pc_src        = 2'd1;
            pc_write_cond = bus.zero;
            state_d       = StFetch;
          end
          OpJ: begin
            pc_src   = 2'd2;
            pc_write = 1'b1;
            state_d  = StFetch;
          end
          default: state_d = StFetch;
        endcase
      end
      StMem: begin
        mem_read  = (opcode_q == OpLw);
        mem_write = (opcode_q == OpSw);
        if (timeout) begin
          mem_err   = 1'b1;
          mem_write = 1'b0;
          state_d   = StFetch;
        end else if (bus.mem_ready) begin
          state_d = (opcode_q == OpLw) ? StWb : StFetch;
        end
      end
      StWb: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode_q == OpRtype);
        mem_to_reg = (opcode_q == OpLw);
        state_d    = StFetch;
      end
      default: state_d = StFetch;
    endcase
    // An edge with reset high aborts the instruction, so nothing may be committed.
    if (reset) begin
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      reg_write     = 1'b0;
    end
  end

  always_comb begin
    alu_sel_w      = '0;
    alu_sel_w[3:0] = alu_sel4;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StFetch;
      opcode_q <= 6'd0;
      funct_q  <= 6'd0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) begin
        opcode_q <= bus.opcode;
        funct_q  <= bus.funct;
      end
    end
  end

  assign bus.state         = state_q;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.ir_write      = ir_write;
  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.pc_src        = pc_src;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_sel       = alu_sel_w;
  assign bus.reg_write     = reg_write;
  assign bus.reg_dst       = reg_dst;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.illegal       = illegal;
  assign bus.mem_err       = mem_err;

endmodule

// File: tb/tb_mc_alu_control_unit.sv
// Bench for mc_alu_control_unit. Each instruction is expanded into its expected
// cycle-by-cycle trace (inputs to drive plus required outputs), then the trace is
// played against the DUT and every cycle is compared.
module tb_mc_alu_control_unit;
  localparam int unsigned SEL_W       = 6;
  localparam int unsigned MEM_TIMEOUT = 15;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [3:0] Add    = 4'b0010;
  localparam logic [3:0] Sub    = 4'b0110;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_read, mem_write, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_src, alu_src_b;
    logic [3:0] alu_sel;
    logic       reg_write, reg_dst, mem_to_reg, illegal, mem_err;
  } outs_t;

  typedef struct {
    logic       rst, rdy, z;
    logic [5:0] op, fn;
    logic       full;  // 0: reset cycle, only write enables are checked
    outs_t      e;
  } cyc_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_alu_control_unit_if #(.SEL_W(SEL_W)) bus ();

  mc_alu_control_unit #(
    .SEL_W      (SEL_W),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_W       (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  cyc_t plan[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, got, exp);
  endtask

  // R-type funct table.
  task automatic funct_op(input logic [5:0] f, output logic ok, output logic [3:0] sel);
    ok = 1'b1;
    case (f)
      6'b100100: sel = 4'b0000;
      6'b100101: sel = 4'b0001;
      6'b100000: sel = 4'b0010;
      6'b100010: sel = 4'b0110;
      6'b101010: sel = 4'b0111;
      6'b100111: sel = 4'b1100;
      6'b000000: sel = 4'b1000;
      6'b000010: sel = 4'b1001;
      6'b100110: sel = 4'b1010;
      default: begin ok = 1'b0; sel = 4'b0000; end
    endcase
  endtask

  function automatic cyc_t blank(input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic rdy);
    cyc_t c;
    c.rst = 1'b0; c.rdy = rdy; c.z = z; c.op = op; c.fn = fn; c.full = 1'b1; c.e = '0;
    return c;
  endfunction

  function automatic outs_t fetch_outs();
    outs_t o = '0;
    o.mem_read  = 1'b1;
    o.alu_src_b = 2'd1;
    o.alu_sel   = Add;
    return o;
  endfunction

  task automatic plan_reset(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank(6'd0, 6'd0, 1'b0, 1'b0);
      c.rst  = 1'b1;
      c.full = 1'b0;
      plan.push_back(c);
    end
  endtask

  // One instruction: fwait fetch stall cycles, mwait MEM stall cycles.
  task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fwait, input int mwait);
    cyc_t c;
    logic ok;
    logic [3:0] sel;
    for (int i = 0; i < fwait; i++) begin
      c = blank(op, fn, z, 1'b0); c.e = fetch_outs(); plan.push_back(c);
    end
    c = blank(op, fn, z, 1'b1); c.e = fetch_outs();
    c.e.ir_write = 1'b1; c.e.pc_write = 1'b1;
    plan.push_back(c);
    funct_op(fn, ok, sel);
    if (op != OpR) ok = (op == OpLw || op == OpSw || op == OpBeq || op == OpAddi || op == OpJ);
    c = blank(op, fn, z, 1'b1);
    c.e.state = 3'd1; c.e.alu_src_b = 2'd3; c.e.alu_sel = Add; c.e.illegal = !ok;
    plan.push_back(c);
    if (!ok) return;
    c = blank(op, fn, z, 1'b1);
    c.e.state = 3'd2;
    if (op == OpR) c.e.alu_sel = sel;
    else if (op == OpBeq) begin
      c.e.alu_sel = Sub; c.e.pc_src = 2'd1; c.e.pc_write_cond = z;
    end else if (op == OpJ) begin
      c.e.pc_src = 2'd2; c.e.pc_write = 1'b1;
    end else begin
      c.e.alu_src_b = 2'd2; c.e.alu_sel = Add;
    end
    plan.push_back(c);
    if (op == OpBeq || op == OpJ) return;
    if (op == OpLw || op == OpSw) begin
      for (int i = 0; i <= mwait; i++) begin
        c = blank(op, fn, z, (i == mwait));
        c.e.state = 3'd3; c.e.mem_read = (op == OpLw); c.e.mem_write = (op == OpSw);
        plan.push_back(c);
      end
      if (op == OpSw) return;
    end
    c = blank(op, fn, z, 1'b1);
    c.e.state = 3'd4; c.e.reg_write = 1'b1;
    c.e.reg_dst = (op == OpR); c.e.mem_to_reg = (op == OpLw);
    plan.push_back(c);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic plan_fetch_timeout();
    cyc_t c;
    for (int i = 1; i <= int'(MEM_TIMEOUT); i++) begin
      c = blank(OpR, 6'b100000, 1'b0, 1'b0);
      c.e = fetch_outs();
      c.e.mem_err = (i == int'(MEM_TIMEOUT));
      plan.push_back(c);
    end
  endtask
`endif

  initial begin
    cyc_t  c;
    outs_t got;
    int    n0;
    logic  hi_ok;
    logic [5:0] fns [8];
    fns = '{6'b100100, 6'b100101, 6'b100010, 6'b101010,
            6'b100111, 6'b000000, 6'b000010, 6'b100110};

    reset = 1'b1;
    bus.opcode = 6'd0; bus.funct = 6'd0; bus.mem_ready = 1'b0; bus.zero = 1'b0;

    plan_reset(2);
    n0 = plan.size(); plan_instr(OpR, 6'b100000, 1'b1, 0, 0);
    check("cpi_r_add", plan.size() - n0, 4);
    check("r_add_exec_sel", 32'(plan[n0 + 2].e.alu_sel), 32'h2);
    check("r_add_wb_dst", 32'(plan[n0 + 3].e.reg_dst), 1);
    n0 = plan.size(); plan_instr(OpLw, 6'd0, 1'b0, 0, 3);
    check("lw_wait3_cycles", plan.size() - n0, 8);
    check("lw_wb_m2r", 32'(plan[n0 + 7].e.mem_to_reg), 1);
    n0 = plan.size(); plan_instr(OpBeq, 6'd0, 1'b1, 0, 0);
    check("cpi_beq", plan.size() - n0, 3);
    check("beq_taken_cond", 32'(plan[n0 + 2].e.pc_write_cond), 1);
    check("beq_sel", 32'(plan[n0 + 2].e.alu_sel), 32'h6);
    plan_instr(OpBeq, 6'd0, 1'b0, 0, 0);
    n0 = plan.size(); plan_instr(6'b111111, 6'd0, 1'b1, 0, 0);
    check("illegal_op_cycles", plan.size() - n0, 2);
    n0 = plan.size(); plan_instr(OpR, 6'b001100, 1'b1, 0, 0);
    check("illegal_fn_pulse", 32'(plan[n0 + 1].e.illegal), 1);
    n0 = plan.size(); plan_instr(OpSw, 6'd0, 1'b1, 2, 1);
    check("sw_stalled_cycles", plan.size() - n0, 7);
    n0 = plan.size(); plan_instr(OpAddi, 6'd0, 1'b1, 0, 0);
    check("cpi_addi", plan.size() - n0, 4);
    n0 = plan.size(); plan_instr(OpJ, 6'd0, 1'b1, 0, 0);
    check("cpi_j", plan.size() - n0, 3);
    for (int i = 0; i < 8; i++) plan_instr(OpR, fns[i], i[0], i % 2, 0);
    // sw aborted by reset while its store is still pending.
    plan_instr(OpSw, 6'd0, 1'b0, 0, 1);
    void'(plan.pop_back());
    plan_reset(1);
`ifdef MEM_TIMEOUT_EN
    plan_fetch_timeout();
`endif
    plan_instr(OpR, 6'b100000, 1'b0, 0, 0);

    #1;
    for (int i = 0; i < plan.size(); i++) begin
      c = plan[i];
      reset = c.rst; bus.mem_ready = c.rdy; bus.zero = c.z;
      bus.opcode = c.op; bus.funct = c.fn;
      #3;
      got = {bus.state, bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write,
             bus.pc_write_cond, bus.pc_src, bus.alu_src_b, bus.alu_sel[3:0],
             bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.illegal, bus.mem_err};
      hi_ok = (bus.alu_sel[SEL_W-1:4] == '0);
      n_total++;
      if (c.full) begin
        if (got === c.e && hi_ok) n_pass++;
        else $display("FAIL cycle%0d outputs: got st=%0d rd=%b wr=%b ir=%b pcw=%b pcc=%b src=%0d srcb=%0d sel=%h rw=%b dst=%b m2r=%b ill=%b err=%b, required st=%0d rd=%b wr=%b ir=%b pcw=%b pcc=%b src=%0d srcb=%0d sel=%h rw=%b dst=%b m2r=%b ill=%b err=%b",
                      i, got.state, got.mem_read, got.mem_write, got.ir_write, got.pc_write,
                      got.pc_write_cond, got.pc_src, got.alu_src_b, bus.alu_sel, got.reg_write,
                      got.reg_dst, got.mem_to_reg, got.illegal, got.mem_err,
                      c.e.state, c.e.mem_read, c.e.mem_write, c.e.ir_write, c.e.pc_write,
                      c.e.pc_write_cond, c.e.pc_src, c.e.alu_src_b, c.e.alu_sel, c.e.reg_write,
                      c.e.reg_dst, c.e.mem_to_reg, c.e.illegal, c.e.mem_err);
      end else begin
        if ({got.mem_write, got.ir_write, got.pc_write, got.pc_write_cond, got.reg_write}
            === 5'b0) n_pass++;
        else $display("FAIL cycle%0d reset_writes: got wr=%b ir=%b pcw=%b pcc=%b rw=%b, required all 0",
                      i, got.mem_write, got.ir_write, got.pc_write, got.pc_write_cond,
                      got.reg_write);
      end
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
